// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier controller.
// Booth operations are encoded as {nz, sub, x2} so the encoder output maps directly onto ALU controls.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DECODE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic nz;
        logic sub;
        logic x2;
    } booth_op_t;

    localparam booth_op_t ZERO = 3'b000;
    localparam booth_op_t PM   = 3'b100;
    localparam booth_op_t P2M  = 3'b101;
    localparam booth_op_t M2M  = 3'b111;
    localparam booth_op_t MM   = 3'b110;

    // Radix-4 digit for the triplet {Q[1], Q[0], q-1} is -2*Q[1] + Q[0] + q-1.
    function automatic booth_op_t booth_decode(input logic [2:0] code);
        booth_op_t op;
        case (code)
            3'b001, 3'b010: op = PM;
            3'b011:         op = P2M;
            3'b100:         op = M2M;
            3'b101, 3'b110: op = MM;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Combinational radix-4 Booth recoder: 3-bit multiplier window to {nz, sub, x2}.
module booth_r4_encoder
    import booth_pkg::*;
(
    input  logic [2:0] q_bits,
    output logic       nz,
    output logic       sub,
    output logic       x2
);

    booth_op_t op;

    always_comb begin
        op = booth_decode(q_bits);
    end

    assign nz  = op.nz;
    assign sub = op.sub;
    assign x2  = op.x2;

endmodule

// File: rtl/booth_r4_controller.sv
// Moore FSM sequencing a radix-4 Booth multiplier datapath: load, per-iteration
// decode / optional add / 2-bit shift, then a one-cycle done pulse.
module booth_r4_controller
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [2:0] q_bits,
    output logic       ld_m,
    output logic       ld_q,
    output logic       clr_a,
    output logic       clr_qm1,
    output logic       ld_a,
    output logic       alu_sub,
    output logic       alu_x2,
    output logic       shift,
    output logic       busy,
    output logic       done
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [2:0]      booth_code_reg, booth_code_next;

    logic [2:0]      enc_in;
    logic            enc_nz;
    logic            enc_sub;
    logic            enc_x2;

    // One recoder serves both decisions: the live window during DECODE (for the
    // add/skip branch) and the latched code afterwards (for the ALU controls).
    assign enc_in = (state_reg == DECODE) ? q_bits : booth_code_reg;

    booth_r4_encoder u_encoder (
        .q_bits (enc_in),
        .nz     (enc_nz),
        .sub    (enc_sub),
        .x2     (enc_x2)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            booth_code_reg <= 3'b000;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            booth_code_reg <= booth_code_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        booth_code_next = booth_code_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                count_next = '0;
                state_next = DECODE;
            end
            DECODE: begin
                booth_code_next = q_bits;
                state_next      = enc_nz ? ADD : SHIFT;
            end
            ADD: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                if (count_reg == LAST_ITER) begin
                    state_next = DONE;
                end else begin
                    count_next = count_reg + CW'(1);
                    state_next = DECODE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ld_m    = 1'b0;
        ld_q    = 1'b0;
        clr_a   = 1'b0;
        clr_qm1 = 1'b0;
        ld_a    = 1'b0;
        alu_sub = 1'b0;
        alu_x2  = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        busy    = (state_reg != IDLE);
        case (state_reg)
            INIT: begin
                ld_m    = 1'b1;
                ld_q    = 1'b1;
                clr_a   = 1'b1;
                clr_qm1 = 1'b1;
            end
            ADD: begin
                ld_a    = 1'b1;
                alu_sub = enc_sub;
                alu_x2  = enc_x2;
            end
            SHIFT: begin
                shift = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_booth_r4_controller.sv
// Self-checking bench: cycle-by-cycle output trace predicted from Booth digit arithmetic.
module tb_booth_r4_controller;

    localparam int WIDTH = 8;
    localparam int ITER  = WIDTH / 2;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [2:0] q_bits;
    logic       ld_m, ld_q, clr_a, clr_qm1, ld_a, alu_sub, alu_x2, shift, busy, done;
    logic [9:0] obs;

    int checks = 0;
    int fails  = 0;
    logic [2:0] seq [ITER];

    booth_r4_controller #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .q_bits  (q_bits),
        .ld_m    (ld_m),
        .ld_q    (ld_q),
        .clr_a   (clr_a),
        .clr_qm1 (clr_qm1),
        .ld_a    (ld_a),
        .alu_sub (alu_sub),
        .alu_x2  (alu_x2),
        .shift   (shift),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign obs = {ld_m, ld_q, clr_a, clr_qm1, ld_a, alu_sub, alu_x2, shift, busy, done};

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic [9:0] vec(input bit init, input bit lda, input bit sub, input bit x2,
                                       input bit sh, input bit bsy, input bit dn);
        return {init, init, init, init, lda, sub, x2, sh, bsy, dn};
    endfunction

    // Expected trace starts with the INIT cycle; one line per operation.
    task automatic run_op(input bit rand_start, input bit hold_at_done, input string tag);
        logic [9:0] trace [$];
        int nz      = 0;
        int d;
        int it      = 0;
        int done_at = -1;
        int lat;
        trace.push_back(vec(1, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < ITER; k++) begin
            trace.push_back(vec(0, 0, 0, 0, 0, 1, 0));
            d = -2 * int'(seq[k][2]) + int'(seq[k][1]) + int'(seq[k][0]);
            if (d != 0) begin
                nz++;
                trace.push_back(vec(0, 1, d < 0, (d == 2) || (d == -2), 0, 1, 0));
            end
            trace.push_back(vec(0, 0, 0, 0, 1, 1, 0));
        end
        trace.push_back(vec(0, 0, 0, 0, 0, 1, 1));
        lat = 2 + 2 * ITER + nz;

        q_bits = seq[0];
        start  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < trace.size(); i++) begin
            check($sformatf("%s cyc%0d", tag, i + 1), 32'(obs), 32'(trace[i]));
            if (done) done_at = i + 1;
            if (ld_a) q_bits = 3'($urandom);
            if (shift) begin
                it++;
                q_bits = (it < ITER) ? seq[it] : 3'($urandom);
            end
            start = rand_start ? 1'($urandom) : 1'b0;
            if (i == trace.size() - 1) start = hold_at_done;
            @(negedge clk);
        end
        check($sformatf("%s latency", tag), 32'(done_at), 32'(lat));
        check($sformatf("%s idle_after", tag), 32'(obs), 32'd0);
        $display("op %s codes=%b %b %b %b latency=%0d done_at=%0d", tag,
                 seq[0], seq[1], seq[2], seq[3], lat, done_at);
        start = 1'b0;
    endtask

    initial begin
        int  sh;
        bit  hit;
        clr    = 1'b1;
        start  = 1'b0;
        q_bits = 3'b000;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(obs), 32'd0);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle_hold%0d", i), 32'(obs), 32'd0);
        end

        // clr beats start in the same cycle
        clr   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("clr_priority", 32'(obs), 32'd0);
        clr   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("clr_priority_idle", 32'(obs), 32'd0);

        for (int k = 0; k < ITER; k++) seq[k] = 3'b000;
        run_op(1'b0, 1'b0, "all_000");
        for (int k = 0; k < ITER; k++) seq[k] = 3'b011;
        run_op(1'b0, 1'b0, "all_011");
        seq[0] = 3'b100; seq[1] = 3'b101; seq[2] = 3'b001; seq[3] = 3'b111;
        run_op(1'b0, 1'b0, "mixed");

        // clr during the second SHIFT aborts the operation
        for (int k = 0; k < ITER; k++) seq[k] = 3'b000;
        q_bits = 3'b000;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sh  = 0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (shift) begin
                sh++;
                if (sh == 2) begin
                    clr = 1'b1;
                    hit = 1'b1;
                end
            end
            if (!hit) @(negedge clk);
        end
        check("clr_mid_reached", 32'(hit), 32'd1);
        @(negedge clk);
        check("clr_mid_outputs", 32'(obs), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        check("clr_mid_idle", 32'(obs), 32'd0);
        run_op(1'b0, 1'b0, "after_clr");

        // start pulses while busy, and start held through DONE
        seq[0] = 3'b010; seq[1] = 3'b110; seq[2] = 3'b000; seq[3] = 3'b100;
        run_op(1'b1, 1'b1, "busy_start");
        seq[0] = 3'b111; seq[1] = 3'b011; seq[2] = 3'b101; seq[3] = 3'b001;
        run_op(1'b1, 1'b0, "chained");

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < ITER; k++) seq[k] = 3'($urandom);
            run_op(1'($urandom), 1'($urandom), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/booth_r4_controller.md
BOOTH_R4_CONTROLLER -- requirements
Module: booth_r4_controller

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and at least 4.
REQ-002 Derived ITER = WIDTH/2 is the number of radix-4 iterations; the iteration counter SHALL be $clog2(ITER) bits wide.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin a multiply; sampled only in IDLE.
REQ-006 q_bits  input  3  {Q[1], Q[0], q_minus1} from the Q shift register and the q-1 flop.
REQ-007 ld_m  output  1  load multiplicand register M.
REQ-008 ld_q  output  1  load multiplier into the Q register.
REQ-009 clr_a  output  1  clear the accumulator shift register A.
REQ-010 clr_qm1  output  1  clear the q-1 flop.
REQ-011 ld_a  output  1  load the ALU result into A.
REQ-012 alu_sub  output  1  ALU subtracts (A - operand) when high, adds when low.
REQ-013 alu_x2  output  1  ALU operand is 2M when high, M when low.
REQ-014 shift  output  1  2-bit arithmetic right shift of the A/Q/q-1 chain.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, INIT, DECODE, ADD, SHIFT, DONE, and all outputs SHALL decode from registered state and the latched code only (Moore).
REQ-018 IDLE with start=1 SHALL go to INIT; otherwise it SHALL stay in IDLE with all outputs 0.
REQ-019 INIT SHALL assert ld_m, ld_q, clr_a and clr_qm1 for exactly one cycle, clear the counter, and then go to DECODE.
REQ-020 DECODE SHALL latch q_bits into booth_code and assert no datapath outputs.
REQ-021 From DECODE, q_bits 000 or 111 SHALL go to SHIFT; any other value SHALL go to ADD.
REQ-022 Booth encoding SHALL be: 001, 010 -> +M; 011 -> +2M; 100 -> -2M; 101, 110 -> -M.
REQ-023 ADD SHALL assert ld_a for one cycle with alu_sub and alu_x2 set from booth_code, then go to SHIFT.
REQ-024 alu_sub and alu_x2 SHALL be 0 in every state except ADD.
REQ-025 SHIFT SHALL assert shift for one cycle.
REQ-026 In SHIFT, if counter == ITER-1 the next state SHALL be DONE; otherwise the counter SHALL increment and the next state SHALL be DECODE.
REQ-027 DONE SHALL assert done for one cycle and then go to IDLE unconditionally.
REQ-028 A start held high through DONE SHALL begin a new operation one cycle later, after one IDLE cycle.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 Latency from the start-sampling edge to done high SHALL be 2 + 2*ITER + (number of non-zero codes) cycles: min 10, max 14 for WIDTH=8.
REQ-031 ld_a and shift SHALL never be high in the same cycle.
REQ-032 At most one of ld_a, shift and INIT's load group SHALL be active in any cycle.

Reset
REQ-033 clr=1 at a clock edge SHALL force IDLE, counter 0 and booth_code 000 from any state, including mid-iteration.
REQ-034 All outputs SHALL be 0 while in the reset state.
REQ-035 clr SHALL take priority over start in the same cycle.
REQ-036 No partial operation SHALL resume after clr; a following start SHALL run a full sequence.

Structure
REQ-037 Shared package booth_pkg SHALL hold the state enum, the Booth code constants (ZERO, PM, P2M, M2M, MM), and the default WIDTH.
REQ-038 One sub-module booth_r4_encoder SHALL map 3-bit q_bits to {nz, sub, x2} combinationally; the FSM SHALL instantiate it once.
REQ-039 The controller SHALL contain no datapath registers beyond the counter and booth_code.

Verification
REQ-040 clr high for 2 cycles, then low -> all outputs 0 and busy 0; start=0 keeps IDLE indefinitely.
REQ-041 start=1 pulse with q_bits held 000 -> INIT group for 1 cycle, then four DECODE/SHIFT pairs (shift high 4 times), ld_a never high, done at cycle 10.
REQ-042 q_bits held 011 -> ld_a=1 with alu_x2=1 and alu_sub=0 in each of 4 ADD cycles, shift follows each ADD, done at cycle 14.
REQ-043 q_bits sequence 100, 101, 001, 111 across iterations -> ADD cycles show (sub, x2) = (1,1), (1,0), (0,0), then no ADD in iteration 4; done at cycle 13.
REQ-044 clr asserted in the SHIFT cycle of iteration 2 -> next cycle IDLE with all outputs 0; a subsequent start yields a full 10-cycle sequence for code 000.
REQ-045 start pulsed during DECODE -> no effect on sequence or timing; start held high through DONE -> one IDLE cycle, then INIT.
